// File: rtl/icmp_rx_buf_ctrl.sv
// icmp_rx_buf_ctrl
//   Sequencing controller for the ICMP receive buffer RAM. Stores one
//   incoming payload byte-stream, tracks its length and 16-bit ones'-complement
//   sum, holds it until tx_start, then replays it as a ready/valid byte stream
//   through a 4-entry output FIFO that hides the RAM read latency.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   rx_valid/rx_data/rx_last/rx_err, rx_ready   input byte stream
//   frm_rdy, frm_len, frm_sum     buffered-frame status (valid while frm_rdy)
//   drop_pulse                    one-cycle pulse when a frame is discarded
//   tx_start                      replay request (honoured only while holding)
//   tx_valid/tx_data/tx_last, tx_ready          output byte stream
//   ram_wr_*                      registered RAM write port
//   ram_rd_addr, ram_rd_data      RAM read port (data RD_LATENCY cycles later)
module icmp_rx_buf_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_last,
  input  logic                  rx_err,
  output logic                  rx_ready,
  output logic                  frm_rdy,
  output logic [ADDR_WIDTH:0]   frm_len,
  output logic [15:0]           frm_sum,
  output logic                  drop_pulse,
  input  logic                  tx_start,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic [7:0]            ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [7:0]            ram_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_DROP,
    S_HOLD,
    S_READ
  } state_t;

  localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH:0]     cnt;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [15:0]             sum;
  logic [ADDR_WIDTH:0]     rd_cnt;
  logic [ADDR_WIDTH:0]     tx_cnt;
  logic [RD_LATENCY-1:0]   rd_pipe;
  logic [7:0]              fifo_mem [4];
  logic [1:0]              f_wp, f_rp;
  logic [2:0]              f_cnt;
  logic [2:0]              inflight;
  logic [2:0]              occ;

  logic rx_ready_s, frm_rdy_s, wr_en_nxt, drop_nxt, rd_issue, clear;
  logic rx_acc, tx_hs, overflow;

  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    // a carry out leaves s[15:0] <= 16'hFFFE, so the fold cannot carry again
    return s[15:0] + {15'b0, s[16]};
  endfunction

  assign rx_acc   = rx_valid & rx_ready;
  assign overflow = (cnt == CNT_FULL);
  assign tx_valid = (f_cnt != 3'd0);
  assign tx_data  = fifo_mem[f_rp];
  assign tx_last  = tx_valid && ((tx_cnt + CNT_ONE) == cnt);
  assign tx_hs    = tx_valid & tx_ready;
  assign rx_ready = rx_ready_s & ~rst;
  assign frm_rdy  = frm_rdy_s;
  assign frm_len  = cnt;
  assign frm_sum  = sum;
  assign ram_rd_addr = rd_cnt[ADDR_WIDTH-1:0];

  // reads in flight plus FIFO occupancy; issue is throttled to keep this < 4
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + {2'b00, rd_pipe[i]};
    end
    occ = inflight + f_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rx_ready_s = 1'b0;
    frm_rdy_s  = 1'b0;
    wr_en_nxt  = 1'b0;
    drop_nxt   = 1'b0;
    rd_issue   = 1'b0;
    clear      = 1'b0;
    case (state)
      S_IDLE: begin
        rx_ready_s = 1'b1;
        if (rx_acc) begin
          wr_en_nxt = 1'b1;
          if (rx_last) begin
            if (rx_err) drop_nxt  = 1'b1;
            else        state_nxt = S_HOLD;
          end else begin
            state_nxt = S_RECV;
          end
        end
      end
      S_RECV: begin
        rx_ready_s = 1'b1;
        if (rx_acc) begin
          if (overflow) begin
            drop_nxt  = 1'b1;
            state_nxt = rx_last ? S_IDLE : S_DROP;
          end else begin
            wr_en_nxt = 1'b1;
            if (rx_last) begin
              if (rx_err) begin
                drop_nxt  = 1'b1;
                state_nxt = S_IDLE;
              end else begin
                state_nxt = S_HOLD;
              end
            end
          end
        end
      end
      S_DROP: begin
        rx_ready_s = 1'b1;
        if (rx_acc && rx_last) state_nxt = S_IDLE;
      end
      S_HOLD: begin
        frm_rdy_s = 1'b1;
        if (tx_start) state_nxt = S_READ;
      end
      S_READ: begin
        frm_rdy_s = 1'b1;
        rd_issue  = (rd_cnt != cnt) && !occ[2];
        if (tx_hs && tx_last) begin
          state_nxt = S_IDLE;
          clear     = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      drop_pulse  <= 1'b0;
      cnt         <= '0;
      wr_ptr      <= '0;
      sum         <= '0;
      rd_cnt      <= '0;
      tx_cnt      <= '0;
      rd_pipe     <= '0;
      f_wp        <= '0;
      f_rp        <= '0;
      f_cnt       <= '0;
      for (int unsigned i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      ram_wr_en  <= wr_en_nxt;
      drop_pulse <= drop_nxt;
      if (wr_en_nxt) begin
        ram_wr_data <= rx_data;
        ram_wr_addr <= (state == S_IDLE) ? '0 : wr_ptr;
      end

      // first byte restarts the frame; even offsets are the high byte
      if (state == S_IDLE && rx_acc) begin
        cnt    <= CNT_ONE;
        wr_ptr <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        sum    <= {rx_data, 8'h00};
      end else if (state == S_RECV && rx_acc && !overflow) begin
        cnt    <= cnt + CNT_ONE;
        wr_ptr <= wr_ptr + 1'b1;
        sum    <= oc_add(sum, cnt[0] ? {8'h00, rx_data} : {rx_data, 8'h00});
      end

      rd_pipe <= {rd_pipe[RD_LATENCY-2:0], rd_issue};
      if (rd_issue) rd_cnt <= rd_cnt + CNT_ONE;

      if (rd_pipe[RD_LATENCY-1]) begin
        fifo_mem[f_wp] <= ram_rd_data;
        f_wp           <= f_wp + 1'b1;
      end
      if (tx_hs) begin
        f_rp   <= f_rp + 1'b1;
        tx_cnt <= tx_cnt + CNT_ONE;
      end
      case ({rd_pipe[RD_LATENCY-1], tx_hs})
        2'b10:   f_cnt <= f_cnt + 1'b1;
        2'b01:   f_cnt <= f_cnt - 1'b1;
        default: f_cnt <= f_cnt;
      endcase

      if (clear) begin
        cnt    <= '0;
        wr_ptr <= '0;
        sum    <= '0;
        rd_cnt <= '0;
        tx_cnt <= '0;
        f_wp   <= '0;
        f_rp   <= '0;
        f_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_icmp_rx_buf_ctrl.sv
// Testbench for icmp_rx_buf_ctrl: behavioural RAM, frame-level reference
// model (byte queue, word-sum arithmetic), randomized gaps and tx_ready.
module tb_icmp_rx_buf_ctrl;
  localparam int AW  = 11;
  localparam int CAP = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid, rx_last, rx_err, rx_ready;
  logic [7:0]    rx_data;
  logic          frm_rdy, drop_pulse;
  logic [AW:0]   frm_len;
  logic [15:0]   frm_sum;
  logic          tx_start, tx_valid, tx_last, tx_ready;
  logic [7:0]    tx_data;
  logic [7:0]    ram_wr_data, ram_rd_data;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic          ram_wr_en;

  int checks = 0;
  int errors = 0;
  logic [7:0] fb [$];

  always #5 clk = ~clk;

  icmp_rx_buf_ctrl #(.ADDR_WIDTH(AW), .RD_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last), .rx_err(rx_err),
    .rx_ready(rx_ready), .frm_rdy(frm_rdy), .frm_len(frm_len), .frm_sum(frm_sum),
    .drop_pulse(drop_pulse), .tx_start(tx_start), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  // external RAM: registered address, registered output
  logic [7:0]    ram [CAP];
  logic [AW-1:0] ra_q;
  logic [7:0]    rd_q;
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    ra_q <= ram_rd_addr;
    rd_q <= ram[ra_q];
  end
  assign ram_rd_data = rd_q;

  function automatic logic [15:0] ref_sum(input int n);
    longint unsigned acc = 0;
    for (int i = 0; i < n; i += 2) begin
      longint unsigned hi = fb[i];
      longint unsigned lo = (i + 1 < n) ? fb[i+1] : 0;
      acc += hi * 256 + lo;
    end
    while ((acc >> 16) != 0) acc = (acc & 64'hFFFF) + (acc >> 16);
    return acc[15:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_seq(input int n);
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'(i));
  endtask

  task automatic fill_rand(input int n);
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
  endtask

  task automatic send_frame(input int n, input bit err, input bit gaps);
    bit ok, exp_drop;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        rx_valid = 1'b0;
        cyc();
        checks++;
        if (ram_wr_en !== 1'b0) begin
          errors++; $display("FAIL gap_wr_en: got %b want 0", ram_wr_en);
        end
      end
      checks++;
      if (rx_ready !== 1'b1) begin
        errors++; $display("FAIL rx_ready_recv byte %0d: got %b want 1", i, rx_ready);
      end
      rx_valid = 1'b1;
      rx_data  = fb[i];
      rx_last  = (i == n - 1);
      rx_err   = (i == n - 1) ? err : 1'($urandom);
      cyc();
      checks++;
      if (ram_wr_en !== (i < CAP)) begin
        errors++; $display("FAIL wr_en byte %0d: got %b want %b", i, ram_wr_en, (i < CAP));
      end else if (i < CAP) begin
        checks++;
        if (ram_wr_addr !== i[AW-1:0] || ram_wr_data !== fb[i]) begin
          errors++;
          $display("FAIL wr_addr_data byte %0d: got %h/%h want %h/%h",
                   i, ram_wr_addr, ram_wr_data, i[AW-1:0], fb[i]);
        end
      end
      exp_drop = (i == CAP) || (i == n - 1 && err && n <= CAP);
      checks++;
      if (drop_pulse !== exp_drop) begin
        errors++; $display("FAIL drop_pulse byte %0d: got %b want %b", i, drop_pulse, exp_drop);
      end
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_err   = 1'b0;
    ok = (n <= CAP) && !err;
    checks++;
    if (frm_rdy !== ok || rx_ready !== !ok) begin
      errors++;
      $display("FAIL frame_end_status: got frm_rdy=%b rx_ready=%b want %b/%b",
               frm_rdy, rx_ready, ok, !ok);
    end
    if (ok) begin
      checks++;
      if (frm_len !== (AW+1)'(n)) begin
        errors++; $display("FAIL frm_len: got %0d want %0d", frm_len, n);
      end
      checks++;
      if (frm_sum !== ref_sum(n)) begin
        errors++; $display("FAIL frm_sum: got %h want %h", frm_sum, ref_sum(n));
      end
    end
    cyc();
    checks++;
    if (drop_pulse !== 1'b0) begin
      errors++; $display("FAIL drop_pulse_width: got %b want 0", drop_pulse);
    end
  endtask

  task automatic replay(input int n, input bit rand_ready);
    int k = 0, t = 1, first = -1;
    bit done = 0, stall = 0, rdy;
    logic [7:0] pd;
    logic pl;
    logic [AW-1:0] ahead;
    tx_start = 1'b1;
    cyc();
    tx_start = 1'b0;
    while (!done && t < 10 * n + 60) begin
      if (first < 0 && tx_valid === 1'b1) first = t;
      ahead = ram_rd_addr - k[AW-1:0];
      checks++;
      if (ahead > 4) begin
        errors++; $display("FAIL rd_ahead: got %0d want <=4", ahead);
      end
      checks++;
      if (frm_rdy !== 1'b1 || rx_ready !== 1'b0) begin
        errors++; $display("FAIL read_status: got frm_rdy=%b rx_ready=%b want 1/0", frm_rdy, rx_ready);
      end
      if (stall) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== pd || tx_last !== pl) begin
          errors++;
          $display("FAIL stall_stable: got v=%b d=%h l=%b want 1/%h/%b", tx_valid, tx_data, tx_last, pd, pl);
        end
      end
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_ready = rdy;
      stall = 0;
      if (tx_valid === 1'b1) begin
        if (rdy) begin
          checks++;
          if (tx_data !== fb[k] || tx_last !== (k == n - 1)) begin
            errors++;
            $display("FAIL tx_byte %0d: got %h last=%b want %h last=%b", k, tx_data, tx_last, fb[k], (k == n - 1));
          end
          if (k == n - 1) done = 1;
          k++;
        end else begin
          stall = 1; pd = tx_data; pl = tx_last;
        end
      end
      cyc();
      t++;
    end
    tx_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL replay_timeout: got %0d bytes want %0d", k, n);
    end else begin
      checks++;
      if (rx_ready !== 1'b1 || frm_rdy !== 1'b0 || tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL after_last: got rx_ready=%b frm_rdy=%b tx_valid=%b want 1/0/0", rx_ready, frm_rdy, tx_valid);
      end
    end
    checks++;
    if (first != 4) begin
      errors++; $display("FAIL first_valid_latency: got %0d want 4", first);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if (rx_ready !== 0 || frm_rdy !== 0 || frm_len !== '0 || frm_sum !== '0 ||
        drop_pulse !== 0 || tx_valid !== 0 || tx_data !== '0 || tx_last !== 0 ||
        ram_wr_en !== 0 || ram_wr_addr !== '0 || ram_wr_data !== '0 || ram_rd_addr !== '0) begin
      errors++;
      $display("FAIL %s: got rdy=%b frdy=%b len=%0d sum=%h drop=%b tv=%b td=%h tl=%b we=%b wa=%h wd=%h ra=%h want all 0",
               tag, rx_ready, frm_rdy, frm_len, frm_sum, drop_pulse, tx_valid, tx_data, tx_last,
               ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 0; rx_data = 0; rx_last = 0; rx_err = 0;
    tx_start = 0; tx_ready = 0;
    repeat (3) cyc();
    check_zero_outputs("reset_values");
    rst = 1'b0;
    cyc();
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++; $display("FAIL rx_ready_after_reset: got %b want 1", rx_ready);
    end
  endtask

  task automatic test_seq64();
    fill_seq(64);
    send_frame(64, 0, 0);
    checks++;
    if (frm_sum !== 16'hE403) begin
      errors++; $display("FAIL seq64_sum: got %h want e403", frm_sum);
    end
    replay(64, 0);
  endtask

  task automatic test_odd3();
    fb.delete();
    fb.push_back(8'hFF); fb.push_back(8'hFF); fb.push_back(8'h01);
    send_frame(3, 0, 0);
    checks++;
    if (frm_sum !== 16'h0100 || frm_len !== 12'd3) begin
      errors++; $display("FAIL odd3: got sum=%h len=%0d want 0100/3", frm_sum, frm_len);
    end
    replay(3, 1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 5; f++) begin
      int n = $urandom_range(1, 120);
      fill_rand(n);
      send_frame(n, 0, 1);
      replay(n, 1);
    end
  endtask

  task automatic test_err_drop();
    fill_rand(10);
    send_frame(10, 1, 1);
    fill_rand(1);
    send_frame(1, 1, 0);
    fill_rand(17);
    send_frame(17, 0, 1);
    replay(17, 1);
  endtask

  task automatic test_hold();
    fill_rand(9);
    send_frame(9, 0, 0);
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_data = 8'hAA; rx_last = 1'b1;
      cyc();
      checks++;
      if (rx_ready !== 0 || ram_wr_en !== 0 || frm_rdy !== 1 || frm_len !== 12'd9) begin
        errors++;
        $display("FAIL hold_rx_blocked: got rdy=%b we=%b frdy=%b len=%0d want 0/0/1/9",
                 rx_ready, ram_wr_en, frm_rdy, frm_len);
      end
    end
    rx_valid = 1'b0; rx_last = 1'b0;
    replay(9, 1);
  endtask

  task automatic test_idle_tx_start();
    tx_start = 1'b1;
    cyc();
    tx_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (tx_valid !== 0 || frm_rdy !== 0 || rx_ready !== 1) begin
        errors++;
        $display("FAIL idle_tx_start: got tv=%b frdy=%b rdy=%b want 0/0/1", tx_valid, frm_rdy, rx_ready);
      end
      cyc();
    end
  endtask

  task automatic test_overflow();
    fill_rand(2052);
    send_frame(2052, 0, 0);
    fill_rand(CAP);
    send_frame(CAP, 0, 0);
    replay(CAP, 0);
  endtask

  task automatic test_reset_mid_read();
    fill_rand(40);
    send_frame(40, 0, 0);
    tx_start = 1'b1;
    cyc();
    tx_start = 1'b0;
    tx_ready = 1'b1;
    repeat (8) cyc();
    rst = 1'b1;
    cyc();
    tx_ready = 1'b0;
    check_zero_outputs("reset_mid_read");
    rst = 1'b0;
    cyc();
    checks++;
    if (rx_ready !== 1 || frm_rdy !== 0 || tx_valid !== 0) begin
      errors++;
      $display("FAIL after_mid_reset: got rdy=%b frdy=%b tv=%b want 1/0/0", rx_ready, frm_rdy, tx_valid);
    end
    fill_rand(25);
    send_frame(25, 0, 1);
    replay(25, 1);
  endtask

  initial begin
    test_reset();
    test_seq64();
    test_odd3();
    test_random();
    test_err_drop();
    test_hold();
    test_idle_tx_start();
    test_overflow();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icmp_rx_buf_ctrl.md
# icmp_rx_buf_ctrl

Sequencing controller for the ICMP receive buffer RAM (8-bit x 2^ADDR_WIDTH simple dual-port, registered output). It stores one incoming ICMP payload byte-stream in the RAM and computes its length and 16-bit ones'-complement sum. It then holds the frame until the echo-reply builder requests it, and replays it as a ready/valid byte stream. The block absorbs the RAM's 2-cycle read latency so that output runs at 1 byte/cycle under continuous tx_ready.

## Interface
Parameters:
- ADDR_WIDTH, 11, RAM address width; buffer capacity is 2^ADDR_WIDTH bytes.
- RD_LATENCY, 2, RAM read latency in cycles (address registered plus output register); fixed at 2.

Ports:
- clk  in  1  single clock; RAM wr_clk and rd_clk are both tied to it.
- rst  in  1  reset, synchronous, active-high.
- rx_valid  in  1  input byte valid.
- rx_data  in  8  input byte.
- rx_last  in  1  last byte of frame; qualified by rx_valid.
- rx_err  in  1  frame error; sampled with rx_last.
- rx_ready  out  1  block accepts an input byte.
- frm_rdy  out  1  complete frame is buffered; level signal.
- frm_len  out  ADDR_WIDTH+1  byte count of the buffered frame; valid while frm_rdy is high.
- frm_sum  out  16  ones'-complement sum of the frame; valid while frm_rdy is high.
- drop_pulse  out  1  one-cycle pulse when a frame is discarded.
- tx_start  in  1  request to replay the buffered frame.
- tx_valid  out  1  output byte valid.
- tx_data  out  8  output byte.
- tx_last  out  1  last output byte.
- tx_ready  in  1  downstream accepts the output byte.
- ram_wr_data  out  8  RAM write data.
- ram_wr_addr  out  ADDR_WIDTH  RAM write address.
- ram_wr_en  out  1  RAM write enable.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_data  in  8  RAM read data; valid 2 cycles after the address is presented.

## Operation
States and transitions:
- IDLE: rx_ready=1. An accepted byte (rx_valid & rx_ready) is written at address 0, count becomes 1, and the state moves to RECV. If that byte also has rx_last, the frame-end rules below apply directly.
- RECV: rx_ready=1. Each accepted byte is written at address wr_ptr, and wr_ptr and count are incremented.
  - On an accepted rx_last with rx_err=0: go to HOLD.
  - On an accepted rx_last with rx_err=1: go to IDLE and pulse drop_pulse.
  - A byte accepted while count == 2^ADDR_WIDTH is an overflow: the byte is not written, drop_pulse fires, and the state moves to DROP. If that byte carries rx_last, go to IDLE instead.
  - A frame of exactly 2^ADDR_WIDTH bytes is legal.
- DROP: rx_ready=1. Bytes are consumed and not written. On accepted rx_last, go to IDLE.
- HOLD: rx_ready=0, frm_rdy=1, frm_len and frm_sum are stable. tx_start moves to READ.
- READ: rx_ready=0, frm_rdy=1.
  - Read addresses 0..frm_len-1 are issued in order.
  - Addresses are issued only while (in-flight reads + output FIFO occupancy) < 4.
  - Returning data is pushed into a 4-entry output FIFO; the FIFO head drives tx_data and tx_valid.
  - tx_last is asserted on the byte at index frm_len-1.
  - After the tx_last handshake: go to IDLE, frm_rdy=0, and counters clear.

Datapath rules:
- Checksum: bytes at even offsets are the high byte and odd offsets the low byte of 16-bit words. An odd-length frame is padded with 0x00. Each addition folds the end-around carry. The sum is not complemented. The sum register clears at frame start.
- tx_start outside HOLD is ignored. rx_valid while rx_ready=0 is not consumed.
- Output stream rule: tx_data, tx_valid and tx_last stay stable while tx_valid=1 and tx_ready=0.
- rst at any time: return to IDLE, flush the FIFO, discard in-flight reads, and clear the sum, count and pointers. A partially received or partially replayed frame is lost.

## Timing
- Reset values: all outputs 0. rx_ready=1 from the first cycle after rst deasserts.
- RAM write signals (ram_wr_en, ram_wr_addr, ram_wr_data) are registered: a byte accepted in cycle N is written at cycle N+1.
- Last byte accepted in cycle N: frm_rdy, frm_len and frm_sum are valid from N+1, and rx_ready=0 from N+1.
- tx_start sampled high in HOLD at cycle T:
  - first ram_rd_addr issued at T+1;
  - data returns at T+3;
  - first tx_valid at T+4.
- With tx_ready held high, one byte is transferred per cycle with no bubbles.
- The tx_last handshake at cycle L gives rx_ready=1 at L+1.
- drop_pulse is asserted in the cycle after the terminating accept.

## Test plan
- 64-byte frame 0x00..0x3F, tx_start, tx_ready=1:
  - frm_len=64;
  - frm_sum is the folded sum of the words 0x0001, 0x0203, …, 0x3E3F;
  - 64 bytes are replayed in order, with tx_last on 0x3F and first tx_valid 4 cycles after tx_start.
- Odd-length 3-byte frame 0xFF,0xFF,0x01:
  - frm_len=3;
  - frm_sum=0x0100, since 0xFFFF plus 0x0100 gives 0x100FF, which folds to 0x0100.
- Replay under random tx_ready, about 50% duty:
  - data and order are unchanged;
  - outputs are stable during stalls;
  - ram_rd_addr never runs more than 4 entries ahead of consumption.
- Error and overflow drops:
  - rx_last with rx_err=1 → drop_pulse, no frm_rdy, next frame accepted normally;
  - a 2049-byte frame with ADDR_WIDTH=11 → drop_pulse at byte 2049, remaining bytes absorbed, return to IDLE;
  - a 2048-byte frame → accepted.
- Hold and restart behaviour:
  - rx_valid high while in HOLD → rx_ready=0 and nothing is written;
  - tx_start pulsed in IDLE → ignored;
  - rst asserted mid-READ → outputs 0, IDLE next cycle, a new frame then buffers correctly.
